bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side client for the team's simple dual-port BRAM (synchronous read, optional output register).
- Accepts a burst request (base address and word count) and drives the BRAM read address.
- Tracks the fixed BRAM read latency and returns the read words as a valid/ready stream with a last-word marker.
- Back-pressure is handled by credit-limited issue into a small skid FIFO, so no word is ever dropped.

Parameters:
- DWIDTH, 32, data word width; must match the BRAM.
- DEPTH, 1024, BRAM depth; AW = log2x(DEPTH).
- DOREG, 1, BRAM output register enable; read latency LAT = DOREG ? 2 : 1 cycles.
- SKID_DEPTH, 4, skid FIFO entries; minimum 2; SKID_DEPTH >= LAT+1 gives full throughput.

Ports:
- clk  in  1  single clock, shared with the BRAM read port.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_base  in  AW  first word address.
- req_len  in  AW+1  word count, 0..DEPTH.
- raddr  out  AW  BRAM read address.
- ren  out  1  marks a real read issue this cycle.
- rdata  in  DWIDTH  BRAM dout.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DWIDTH  stream word.
- out_last  out  1  final word of the burst; qualified by out_valid.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - state to IDLE, raddr, the remaining-word counter, the in-flight pipe and FIFO pointers/count;
  - outputs ren, out_valid, out_last, busy and done to 0;
  - req_ready to 0 while rst is high, then 1 in IDLE.
- Reset mid-burst: all in-flight and buffered words are discarded; no done pulse; stale BRAM dout is ignored.
- IDLE:
  - req_ready=1.
  - On accept: raddr<=req_base, remaining<=req_len.
  - req_len=0: done=1 on the next cycle, no data, state stays IDLE.
  - req_len>0: go to RUN, busy=1.
- RUN:
  - issue = (remaining != 0) & (fifo_count + inflight < SKID_DEPTH).
  - On issue: ren=1 for the current raddr; then raddr<=raddr+1 modulo DEPTH (DEPTH-1 wraps to 0), and remaining decrements.
  - When the final word issues, go to DRAIN.
- In-flight tracking:
  - LAT-bit valid shift register plus a last-tag shift register.
  - A bit leaving the tail means rdata is valid in that cycle; it is written to the FIFO together with its last tag.
  - inflight = popcount of the valid pipe.
- Output stream:
  - The FIFO head drives out_data, out_last and out_valid.
  - Pop when out_valid & out_ready.
  - A push and a pop in the same cycle are both legal; the count is unchanged.
  - Word order is strictly address order.
  - out_valid/out_data must hold stable while out_ready=0.
- DRAIN:
  - Wait until inflight==0 and the word carrying out_last has been popped.
  - Then done=1 for one cycle, busy=0, state to IDLE.
- Throughput:
  - 1 word/cycle with out_ready held high and SKID_DEPTH >= LAT+1.
  - Issue-to-out_valid latency is LAT+1 cycles (registered FIFO output).
- Invariant: the credit rule guarantees the FIFO never overflows. Assertion: no push when fifo_count==SKID_DEPTH.
- Requests during RUN/DRAIN are not accepted (req_ready=0).
- req_len > DEPTH is illegal; flagged by a simulation assertion.

Test Plan:
- Basic burst, DOREG=1, memory preloaded mem[i]=i+0x100: req_base=5, req_len=4, out_ready=1 -> 0x105, 0x106, 0x107, 0x108 on consecutive cycles; out_last on 0x108; done pulse once; busy low afterwards.
- Wrap-around, DEPTH=1024: req_base=1022, req_len=4 -> addresses 1022, 1023, 0, 1 issued in order; data order matches.
- Back-pressure, req_len=16: out_ready toggles with a 1-of-3 pattern -> all 16 words delivered in order, none lost or duplicated; FIFO count never exceeds 4; out_data stable while stalled.
- Zero length: req_len=0 -> no ren, no out_valid; done pulse on the cycle after accept.
- Reset mid-burst: rst asserted for 1 cycle after 3 of 8 words are issued -> out_valid=0 and busy=0 the next cycle; a new request base=0, len=2 returns mem[0], mem[1] only.
- DOREG=0, SKID_DEPTH=2, req_len=8, out_ready=1 -> 1 word/cycle; first out_valid 2 cycles after the first ren.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side client for the simple dual-port BRAM. A burst request (base
//   address, word count) is turned into a sequence of BRAM reads. The fixed
//   read latency is tracked by a small valid/last pipe, and returning words
//   land in a skid FIFO whose head drives a valid/ready output stream.
//   Reads are only issued while the FIFO plus the words still in flight
//   leave room for them, so back-pressure never drops a word.
//
// Ports
//   clk, rst         single clock (shared with the BRAM read port), sync
//                    active-high reset
//   req_valid/ready  burst request handshake; accepted only when idle
//   req_base         first word address
//   req_len          word count, 0..DEPTH
//   raddr, ren       BRAM read address and read-issue strobe
//   rdata            BRAM dout
//   out_valid/ready  output stream handshake
//   out_data         stream word
//   out_last         final word of the burst (qualified by out_valid)
//   busy             burst in progress
//   done             one-cycle pulse when a burst has fully drained
module bram_stream_reader #(
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 1024,
  parameter int DOREG      = 1,
  parameter int SKID_DEPTH = 4,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_base,
  input  logic [AW:0]       req_len,
  output logic [AW-1:0]     raddr,
  output logic              ren,
  input  logic [DWIDTH-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int LAT = (DOREG != 0) ? 2 : 1;
  localparam int PW  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW  = $clog2(SKID_DEPTH + 1);
  localparam int SW  = $clog2(SKID_DEPTH + LAT + 2);
  localparam int EW  = DWIDTH + 1;

  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [AW:0]     remaining;
  logic [LAT-1:0]  vld_p;
  logic [LAT-1:0]  last_p;

  logic [EW-1:0]   fifo_mem [SKID_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   head;

  logic [SW-1:0]   inflight;
  logic            credit_ok;
  logic            issue;
  logic            issue_last;
  logic            accept;
  logic            push;
  logic            pop;
  logic            drain_done;

  // Address advance modulo DEPTH (works for non-power-of-two depths too).
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == ADDR_MAX) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + SW'(vld_p[i]);
    end
  end

  assign req_ready = (state == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  assign out_valid = (fifo_count != '0);
  assign head      = fifo_mem[rd_ptr];
  assign out_data  = head[DWIDTH-1:0];
  assign out_last  = out_valid & head[DWIDTH];
  assign pop       = out_valid & out_ready;

  // A word popped this cycle frees its slot in time for a read issued now,
  // which is what lets SKID_DEPTH = LAT+1 sustain one word per cycle.
  assign credit_ok  = (SW'(fifo_count) + inflight) < (SW'(SKID_DEPTH) + SW'(pop));
  assign issue      = (state == S_RUN) & ~rst & (remaining != '0) & credit_ok;
  assign issue_last = issue & (remaining == (AW+1)'(1));
  assign ren        = issue;

  // Tail of the latency pipe: rdata carries a real word this cycle.
  assign push = vld_p[LAT-1];

  // Last word is leaving (or has left) the FIFO and nothing is still in flight.
  assign drain_done = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  // ---- stage p0: request / issue control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      raddr     <= '0;
      remaining <= '0;
      vld_p     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done  <= 1'b0;
      vld_p <= (vld_p << 1) | LAT'(issue);
      case (state)
        S_IDLE: begin
          if (accept) begin
            raddr     <= req_base;
            remaining <= req_len;
            if (req_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            raddr     <= addr_inc(raddr);
            remaining <= remaining - 1'b1;
            if (issue_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p1..pLAT: last tag travels with the BRAM read latency ----
  always_ff @(posedge clk) begin
    last_p <= (last_p << 1) | LAT'(issue_last);
  end

  // ---- stage pLAT+1: skid FIFO ----
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {last_p[LAT-1], rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (fifo_count == CW'(SKID_DEPTH))))
        else $error("skid FIFO push while full");
      assert (!(accept && (req_len > LEN_MAX)))
        else $error("req_len larger than DEPTH");
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader. Instance a: DEPTH=1024, DOREG=1,
// SKID_DEPTH=4. Instance b: DEPTH=64, DOREG=0, SKID_DEPTH=2. Expected words
// and addresses are pushed when a request is issued; monitors pop and compare.
module tb_bram_stream_reader;

  localparam int A_DEPTH = 1024;
  localparam int A_AW    = 10;
  localparam int A_SKID  = 4;
  localparam int A_LAT   = 2;
  localparam int B_DEPTH = 64;
  localparam int B_AW    = 6;
  localparam int B_SKID  = 2;
  localparam int B_LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // instance a signals
  logic            a_req_valid, a_req_ready, a_ren, a_out_valid, a_out_ready;
  logic            a_out_last, a_busy, a_done;
  logic [A_AW-1:0] a_req_base, a_raddr;
  logic [A_AW:0]   a_req_len;
  logic [31:0]     a_rdata, a_out_data;
  // instance b signals
  logic            b_req_valid, b_req_ready, b_ren, b_out_valid, b_out_ready;
  logic            b_out_last, b_busy, b_done;
  logic [B_AW-1:0] b_req_base, b_raddr;
  logic [B_AW:0]   b_req_len;
  logic [31:0]     b_rdata, b_out_data;

  bram_stream_reader #(.DWIDTH(32), .DEPTH(A_DEPTH), .DOREG(1), .SKID_DEPTH(A_SKID)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_base(a_req_base), .req_len(a_req_len), .raddr(a_raddr), .ren(a_ren),
    .rdata(a_rdata), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy), .done(a_done)
  );

  bram_stream_reader #(.DWIDTH(32), .DEPTH(B_DEPTH), .DOREG(0), .SKID_DEPTH(B_SKID)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_base(b_req_base), .req_len(b_req_len), .raddr(b_raddr), .ren(b_ren),
    .rdata(b_rdata), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  // BRAM models: synchronous read, optional always-enabled output register.
  logic [31:0] mem_a [A_DEPTH];
  logic [31:0] mem_b [B_DEPTH];
  logic [31:0] a_q1, a_q2, b_q1;
  always @(posedge clk) begin
    if (a_ren) a_q1 <= mem_a[a_raddr];
    a_q2 <= a_q1;
    if (b_ren) b_q1 <= mem_b[b_raddr];
  end
  assign a_rdata = a_q2;
  assign b_rdata = b_q1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_max(input string name, input longint act, input longint mx);
    n_vec++;
    if (act > mx) begin
      n_err++;
      $display("FAIL %s: got %0d, allowed at most %0d", name, act, mx);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // scoreboards
  logic [32:0] a_expq[$];
  int          a_addrq[$];
  logic [32:0] b_expq[$];
  int          b_addrq[$];

  int a_iss = 0, a_pop = 0, a_burst_ren = 0, a_burst_pop = 0, a_done_cnt = 0;
  int a_first_ren = -1, a_first_vld = -1, a_first_pop = -1, a_last_pop = -1;
  int b_iss = 0, b_pop = 0, b_burst_pop = 0, b_done_cnt = 0;
  int b_first_ren = -1, b_last_ren = -1, b_first_vld = -1, b_first_pop = -1, b_last_pop = -1;

  // out_ready driver for instance a: 0 = always, 1 = one cycle in three, 2 = random
  int rdy_mode = 0;
  initial begin : rdy_drv
    int k;
    k = 0;
    a_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       a_out_ready = 1'b1;
        1:       a_out_ready = ((k % 3) == 0);
        default: a_out_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  initial begin : mon_a
    logic [32:0] e;
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk_max("a_outstanding", a_iss - a_pop, A_SKID);
        if (a_ren) begin
          if (a_addrq.size() == 0) fail("a_unexpected_ren");
          else chk("a_raddr", a_raddr, a_addrq.pop_front());
          a_iss++;
          a_burst_ren++;
          if (a_first_ren < 0) a_first_ren = cyc;
        end
        if (prev_stall) begin
          chk("a_stall_valid", a_out_valid, 1);
          chk("a_stall_data", a_out_data, prev_data);
        end
        if (a_out_valid && (a_first_vld < 0)) a_first_vld = cyc;
        if (a_out_valid && a_out_ready) begin
          if (a_expq.size() == 0) fail("a_unexpected_word");
          else begin
            e = a_expq.pop_front();
            chk("a_data", a_out_data, e[31:0]);
            chk("a_last", a_out_last, e[32]);
          end
          a_pop++;
          a_burst_pop++;
          if (a_first_pop < 0) a_first_pop = cyc;
          a_last_pop = cyc;
        end
        prev_stall = a_out_valid && !a_out_ready;
        prev_data  = a_out_data;
        if (a_done) a_done_cnt++;
      end
    end
  end

  initial begin : mon_b
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk_max("b_outstanding", b_iss - b_pop, B_SKID);
        if (b_ren) begin
          if (b_addrq.size() == 0) fail("b_unexpected_ren");
          else chk("b_raddr", b_raddr, b_addrq.pop_front());
          b_iss++;
          if (b_first_ren < 0) b_first_ren = cyc;
          b_last_ren = cyc;
        end
        if (b_out_valid && (b_first_vld < 0)) b_first_vld = cyc;
        if (b_out_valid && b_out_ready) begin
          if (b_expq.size() == 0) fail("b_unexpected_word");
          else begin
            e = b_expq.pop_front();
            chk("b_data", b_out_data, e[31:0]);
            chk("b_last", b_out_last, e[32]);
          end
          b_pop++;
          b_burst_pop++;
          if (b_first_pop < 0) b_first_pop = cyc;
          b_last_pop = cyc;
        end
        if (b_done) b_done_cnt++;
      end
    end
  end

  // Issue a request on instance a; returns just after the accepting edge.
  task automatic a_burst(input int base, input int len);
    int t;
    int idx;
    t = 0;
    while (!a_req_ready && (t < 2000)) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!a_req_ready) fail("a_req_ready_timeout");
    a_done_cnt  = 0;
    a_burst_ren = 0;
    a_burst_pop = 0;
    a_first_ren = -1;
    a_first_vld = -1;
    a_first_pop = -1;
    a_last_pop  = -1;
    for (int i = 0; i < len; i++) begin
      idx = (base + i) % A_DEPTH;
      a_expq.push_back({(i == len - 1), mem_a[idx]});
      a_addrq.push_back(idx);
    end
    a_req_base  = A_AW'(base);
    a_req_len   = (A_AW+1)'(len);
    a_req_valid = 1'b1;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    if (len > 0) chk("a_busy_after_accept", a_busy, 1);
  endtask

  task automatic a_wait_done(input int budget);
    int t;
    t = 0;
    while (t < budget) begin
      @(negedge clk);
      if (a_done) break;
      t++;
    end
    if (t >= budget) fail("a_done_timeout");
    @(posedge clk);
    #1;
    chk("a_done_pulse_count", a_done_cnt, 1);
    chk("a_done_one_cycle", a_done, 0);
    chk("a_busy_after_done", a_busy, 0);
    chk("a_words_left", a_expq.size(), 0);
    chk("a_addrs_left", a_addrq.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t;
    int idx;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_base = '0; a_req_len = '0;
    b_req_valid = 1'b0; b_req_base = '0; b_req_len = '0;
    b_out_ready = 1'b1;
    for (int i = 0; i < A_DEPTH; i++) mem_a[i] = 32'(i + 'h100);
    for (int i = 0; i < B_DEPTH; i++) mem_b[i] = 32'(i * 7 + 3);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("a_req_ready_in_reset", a_req_ready, 0);
    chk("b_req_ready_in_reset", b_req_ready, 0);
    rst = 1'b0;
    #1;
    chk("a_req_ready_idle", a_req_ready, 1);
    chk("b_req_ready_idle", b_req_ready, 1);
    chk("a_busy_reset", a_busy, 0);
    chk("a_done_reset", a_done, 0);
    chk("a_out_valid_reset", a_out_valid, 0);
    chk("a_out_last_reset", a_out_last, 0);
    chk("a_ren_reset", a_ren, 0);
    @(posedge clk);
    #1;

    // basic burst, full rate
    rdy_mode = 0;
    a_burst(5, 4);
    a_wait_done(200);
    chk("basic_latency", a_first_vld - a_first_ren, A_LAT + 1);
    chk("basic_consecutive", a_last_pop - a_first_pop, 3);
    chk("basic_word_count", a_burst_pop, 4);

    // address wrap
    a_burst(1022, 4);
    a_wait_done(200);
    chk("wrap_ren_count", a_burst_ren, 4);
    chk("wrap_word_count", a_burst_pop, 4);

    // back-pressure, one ready cycle in three
    rdy_mode = 1;
    a_burst(100, 16);
    a_wait_done(1000);
    chk("bp_word_count", a_burst_pop, 16);
    rdy_mode = 0;

    // zero length
    a_burst(7, 0);
    chk("zero_done_next_cycle", a_done, 1);
    chk("zero_busy", a_busy, 0);
    @(posedge clk);
    #1;
    chk("zero_done_cleared", a_done, 0);
    chk("zero_no_ren", a_burst_ren, 0);
    chk("zero_no_valid", a_first_vld, -1);

    // reset in the middle of a burst
    a_burst(200, 8);
    t = 0;
    while ((a_burst_ren < 3) && (t < 100)) begin
      @(posedge clk);
      t++;
    end
    if (a_burst_ren < 3) fail("rst_mid_issue_timeout");
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", a_out_valid, 0);
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_ren_count", a_burst_ren, 3);
    a_expq.delete();
    a_addrq.delete();
    a_iss = 0;
    a_pop = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_no_done", a_done_cnt, 0);
    chk("rst_mid_still_empty", a_out_valid, 0);
    a_burst(0, 2);
    a_wait_done(200);
    chk("rst_mid_new_count", a_burst_pop, 2);

    // DOREG=0, SKID_DEPTH=2 instance, wraps inside DEPTH=64
    b_burst_pop = 0; b_done_cnt = 0;
    b_first_ren = -1; b_last_ren = -1; b_first_vld = -1; b_first_pop = -1; b_last_pop = -1;
    for (int i = 0; i < 8; i++) begin
      idx = (60 + i) % B_DEPTH;
      b_expq.push_back({(i == 7), mem_b[idx]});
      b_addrq.push_back(idx);
    end
    b_req_base  = B_AW'(60);
    b_req_len   = (B_AW+1)'(8);
    b_req_valid = 1'b1;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (b_done) break;
      t++;
    end
    if (t >= 200) fail("b_done_timeout");
    @(posedge clk);
    #1;
    chk("b_latency", b_first_vld - b_first_ren, B_LAT + 1);
    chk("b_issue_rate", b_last_ren - b_first_ren, 7);
    chk("b_output_rate", b_last_pop - b_first_pop, 7);
    chk("b_word_count", b_burst_pop, 8);
    chk("b_done_count", b_done_cnt, 1);
    chk("b_busy_after", b_busy, 0);
    chk("b_words_left", b_expq.size(), 0);

    // randomized bursts over random memory contents and random back-pressure
    for (int i = 0; i < A_DEPTH; i++) mem_a[i] = $urandom;
    rdy_mode = 2;
    for (int n = 0; n < 25; n++) begin
      a_burst(int'($urandom_range(0, A_DEPTH - 1)), int'($urandom_range(0, 24)));
      a_wait_done(2000);
    end

    // full-depth burst
    rdy_mode = 0;
    a_burst(int'($urandom_range(0, A_DEPTH - 1)), A_DEPTH);
    a_wait_done(3000);
    chk("full_depth_count", a_burst_pop, A_DEPTH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
